// File: rtl/matmul_sequencer.sv
// Sequences one fused multiply-add unit through C = A x B, one C element at a time.
// Optional MATSEQ_PERF_EN adds busy-cycle and write-stall performance counters.
module matmul_sequencer #(
    parameter int WIDTH  = 16,
    parameter int DIM_W  = 4,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  dim_m,
    input  logic [DIM_W-1:0]  dim_k,
    input  logic [DIM_W-1:0]  dim_n,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] c_base,
    output logic              busy,
    output logic              done,
    output logic              a_rd_en,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic [ADDR_W-1:0] b_rd_addr,
    input  logic [WIDTH-1:0]  a_rd_data,
    input  logic [WIDTH-1:0]  b_rd_data,
    output logic              mac_load,
    output logic [WIDTH-1:0]  mac_seed,
    output logic              mac_valid,
    output logic [WIDTH-1:0]  mac_a,
    output logic [WIDTH-1:0]  mac_b,
    input  logic [WIDTH-1:0]  mac_acc,
    output logic              c_wr_en,
    output logic [ADDR_W-1:0] c_wr_addr,
    output logic [WIDTH-1:0]  c_wr_data,
    input  logic              c_wr_ready
`ifdef MATSEQ_PERF_EN
    ,
    output logic [31:0]       perf_cycles,
    output logic [31:0]       perf_stalls
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_ISSUE, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t              r_state;
    logic [DIM_W-1:0]    r_dm, r_dk, r_dn;
    logic [ADDR_W-1:0]   r_a_base, r_b_base, r_c_base;
    logic [DIM_W-1:0]    r_i, r_j, r_k;
    logic                r_drain;
    logic                r_busy, r_done, r_rd_en, r_mac_load, r_mac_valid;
    logic [ADDR_W-1:0]   r_a_addr, r_b_addr;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;

    logic                w_dim_zero, w_start_acc;
    logic                w_k_last, w_j_last, w_i_last;
    logic [DIM_W-1:0]    w_k_inc, w_j_next, w_i_next;

    // base + row*stride + col, all at address width so products wrap
    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [ADDR_W-1:0] base,
        input logic [DIM_W-1:0]  row,
        input logic [DIM_W-1:0]  stride,
        input logic [DIM_W-1:0]  col
    );
        logic [ADDR_W-1:0] prod;
        prod = ADDR_W'(row) * ADDR_W'(stride);
        return base + prod + ADDR_W'(col);
    endfunction

    assign w_dim_zero  = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
    assign w_start_acc = (r_state == S_IDLE) && start;
    assign w_k_last    = (r_k == r_dk - DIM_W'(1));
    assign w_j_last    = (r_j == r_dn - DIM_W'(1));
    assign w_i_last    = (r_i == r_dm - DIM_W'(1));
    assign w_k_inc     = r_k + DIM_W'(1);
    assign w_j_next    = w_j_last ? '0 : r_j + DIM_W'(1);
    assign w_i_next    = w_j_last ? r_i + DIM_W'(1) : r_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dm        <= '0;
            r_dk        <= '0;
            r_dn        <= '0;
            r_a_base    <= '0;
            r_b_base    <= '0;
            r_c_base    <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_drain     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_rd_en     <= 1'b0;
            r_mac_load  <= 1'b0;
            r_mac_valid <= 1'b0;
            r_a_addr    <= '0;
            r_b_addr    <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_mac_valid <= r_rd_en;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_dm     <= dim_m;
                        r_dk     <= dim_k;
                        r_dn     <= dim_n;
                        r_a_base <= a_base;
                        r_b_base <= b_base;
                        r_c_base <= c_base;
                        r_i      <= '0;
                        r_j      <= '0;
                        r_k      <= '0;
                        if (w_dim_zero) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_busy     <= 1'b1;
                            r_mac_load <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    r_mac_load <= 1'b0;
                    r_state    <= S_ISSUE;
                    r_k        <= '0;
                    r_rd_en    <= 1'b1;
                    r_a_addr   <= f_addr(r_a_base, r_i, r_dk, '0);
                    r_b_addr   <= f_addr(r_b_base, '0, r_dn, r_j);
                end
                S_ISSUE: begin
                    if (w_k_last) begin
                        r_rd_en <= 1'b0;
                        r_drain <= 1'b0;
                        r_state <= S_DRAIN;
                    end else begin
                        r_k      <= w_k_inc;
                        r_a_addr <= f_addr(r_a_base, r_i, r_dk, w_k_inc);
                        r_b_addr <= f_addr(r_b_base, w_k_inc, r_dn, r_j);
                    end
                end
                S_DRAIN: begin
                    // second drain cycle: mac_acc now holds the final accumulate
                    if (r_drain) begin
                        r_drain   <= 1'b0;
                        r_state   <= S_WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_data <= mac_acc;
                        r_wr_addr <= f_addr(r_c_base, r_i, r_dn, r_j);
                    end else begin
                        r_drain <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (c_wr_ready) begin
                        r_wr_en <= 1'b0;
                        r_j     <= w_j_next;
                        r_i     <= w_i_next;
                        if (w_j_last && w_i_last) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_LOAD;
                            r_mac_load <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign a_rd_en   = r_rd_en;
    assign b_rd_en   = r_rd_en;
    assign a_rd_addr = r_a_addr;
    assign b_rd_addr = r_b_addr;
    assign mac_load  = r_mac_load;
    assign mac_seed  = '0;
    assign mac_valid = r_mac_valid;
    // gated so the operand bus is quiet outside valid beats
    assign mac_a     = r_mac_valid ? a_rd_data : '0;
    assign mac_b     = r_mac_valid ? b_rd_data : '0;
    assign c_wr_en   = r_wr_en;
    assign c_wr_addr = r_wr_addr;
    assign c_wr_data = r_wr_data;

`ifdef MATSEQ_PERF_EN
    logic [31:0] r_perf_cycles, r_perf_stalls;

    always_ff @(posedge clk) begin
        if (rst || w_start_acc) begin
            r_perf_cycles <= '0;
            r_perf_stalls <= '0;
        end else begin
            if (r_busy && (r_perf_cycles != '1))
                r_perf_cycles <= r_perf_cycles + 32'd1;
            if ((r_state == S_WRITE) && !c_wr_ready && (r_perf_stalls != '1))
                r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_cycles = r_perf_cycles;
    assign perf_stalls = r_perf_stalls;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer with a scratchpad, MAC model and write-port monitor.
module tb_matmul_sequencer;
    localparam int W  = 16;
    localparam int DW = 4;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst, start;
    logic [DW-1:0] dim_m, dim_k, dim_n;
    logic [AW-1:0] a_base, b_base, c_base;
    logic          busy, done, a_rd_en, b_rd_en;
    logic [AW-1:0] a_rd_addr, b_rd_addr;
    logic [W-1:0]  a_rd_data, b_rd_data;
    logic          mac_load, mac_valid;
    logic [W-1:0]  mac_seed, mac_a, mac_b, mac_acc;
    logic          c_wr_en;
    logic [AW-1:0] c_wr_addr;
    logic [W-1:0]  c_wr_data;
    logic          c_wr_ready = 1'b1;
`ifdef MATSEQ_PERF_EN
    logic [31:0]   perf_cycles, perf_stalls;
`endif

    matmul_sequencer #(.WIDTH(W), .DIM_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dim_m(dim_m), .dim_k(dim_k), .dim_n(dim_n),
        .a_base(a_base), .b_base(b_base), .c_base(c_base),
        .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .b_rd_en(b_rd_en),
        .a_rd_addr(a_rd_addr), .b_rd_addr(b_rd_addr),
        .a_rd_data(a_rd_data), .b_rd_data(b_rd_data),
        .mac_load(mac_load), .mac_seed(mac_seed), .mac_valid(mac_valid),
        .mac_a(mac_a), .mac_b(mac_b), .mac_acc(mac_acc),
        .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
        .c_wr_ready(c_wr_ready)
`ifdef MATSEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    // scratchpad with one-cycle read latency and a modular MAC
    logic [W-1:0] mem [0:(1<<AW)-1];
    logic [W-1:0] acc = '0;
    assign mac_acc = acc;
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= mem[b_rd_addr];
        if (mac_load) acc <= mac_seed;
        else if (mac_valid) acc <= acc + mac_a * mac_b;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // monitor state, sampled on the falling edge
    int            busy_cnt, done_cnt, rd_cnt, load_cnt, wr_seen, overlap, n_wr, n_rd;
    logic [AW-1:0] wr_addr_log [0:15];
    logic [W-1:0]  wr_data_log [0:15];
    logic [AW-1:0] rd_addr_log [0:3];
    bit            stall_mode = 1'b0;
    int            stall_wait = 0;
    logic          prev_en = 1'b0, prev_ready = 1'b1;
    logic [AW-1:0] prev_addr;
    logic [W-1:0]  prev_data;

    always @(negedge clk) begin
        if (c_wr_en && stall_mode && stall_wait < 3) begin
            c_wr_ready = 1'b0;
            stall_wait++;
        end else begin
            c_wr_ready = 1'b1;
        end
        if (prev_en && !prev_ready)
            chk("stall_hold", {35'd0, c_wr_en, c_wr_addr, c_wr_data, a_rd_en, mac_valid},
                {35'd0, 1'b1, prev_addr, prev_data, 2'b00});
        if (c_wr_en && c_wr_ready) begin
            if (n_wr < 16) begin
                wr_addr_log[n_wr] = c_wr_addr;
                wr_data_log[n_wr] = c_wr_data;
            end
            n_wr++;
            stall_wait = 0;
        end
        prev_en    = c_wr_en;
        prev_ready = c_wr_ready;
        prev_addr  = c_wr_addr;
        prev_data  = c_wr_data;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (a_rd_en) begin
            if (n_rd < 4) rd_addr_log[n_rd] = a_rd_addr;
            n_rd++;
            rd_cnt++;
        end
        if (mac_load) load_cnt++;
        if (mac_load && mac_valid) overlap++;
        if (c_wr_en) wr_seen++;
    end

    task automatic clear_logs();
        busy_cnt = 0; done_cnt = 0; rd_cnt = 0; load_cnt = 0;
        wr_seen = 0; overlap = 0; n_wr = 0; n_rd = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int lat;

    task automatic run_cmd(input int m, input int k, input int n,
                           input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                           input logic [AW-1:0] cb, input bit mid_start);
        clear_logs();
        dim_m = DW'(m); dim_k = DW'(k); dim_n = DW'(n);
        a_base = ab; b_base = bb; c_base = cb;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = -1;
        for (int c = 1; c <= 3000; c++) begin
            if (mid_start && c == 6) begin
                dim_m = 1; dim_k = 1; dim_n = 1;
                a_base = 10'h1F0; b_base = 10'h1F1; c_base = 10'h1F2;
                start = 1'b1;
            end
            tick();
            start = 1'b0;
            if (done_cnt > 0) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) chk("cmd_timeout", 64'd0, 64'd1);
        repeat (3) tick();
    endtask

    task automatic check_2x2(input string tag);
        logic [W-1:0] exp_d [0:3];
        exp_d[0] = 16'd19; exp_d[1] = 16'd22; exp_d[2] = 16'd43; exp_d[3] = 16'd50;
        chk({tag, "_nwr"}, 64'(n_wr), 64'd4);
        for (int e = 0; e < 4; e++) begin
            chk({tag, "_addr"}, 64'(wr_addr_log[e]), 64'(10'h020 + e));
            chk({tag, "_data"}, 64'(wr_data_log[e]), 64'(exp_d[e]));
        end
        chk({tag, "_done"}, 64'(done_cnt), 64'd1);
        chk({tag, "_overlap"}, 64'(overlap), 64'd0);
    endtask

    initial begin
        for (int a = 0; a < (1 << AW); a++) mem[a] = '0;
        mem[10'h000] = 16'd1; mem[10'h001] = 16'd2; mem[10'h002] = 16'd3; mem[10'h003] = 16'd4;
        mem[10'h010] = 16'd5; mem[10'h011] = 16'd6; mem[10'h012] = 16'd7; mem[10'h013] = 16'd8;
        mem[10'h100] = 16'h00FF; mem[10'h101] = 16'h0001;
        mem[10'h200] = 16'h0101; mem[10'h201] = 16'h0001;
        mem[10'h3FF] = 16'd2; mem[10'h300] = 16'd5; mem[10'h301] = 16'd7;
        mem[10'h050] = 16'd3; mem[10'h060] = 16'd4;

        rst = 1'b1; start = 1'b0;
        dim_m = '0; dim_k = '0; dim_n = '0;
        a_base = '0; b_base = '0; c_base = '0;
        repeat (3) tick();
        chk("rst_ctrl", {60'd0, busy, done, a_rd_en, mac_load}, 64'd0);
        chk("rst_wr", {27'd0, c_wr_en, c_wr_addr, c_wr_data, mac_valid, b_rd_en, 8'd0}, 64'd0);
        chk("rst_addr", {44'd0, a_rd_addr, b_rd_addr}, 64'd0);
        rst = 1'b0;
        tick();

        // basic 2x2x2 product
        run_cmd(2, 2, 2, 10'h000, 10'h010, 10'h020, 1'b0);
        check_2x2("mm2");
        chk("mm2_busy", 64'(busy_cnt), 64'd24);

        // write backpressure, 3 stall cycles per element
        stall_mode = 1'b1;
        run_cmd(2, 2, 2, 10'h000, 10'h010, 10'h020, 1'b0);
        stall_mode = 1'b0;
        check_2x2("bp");
        chk("bp_busy", 64'(busy_cnt), 64'd36);
`ifdef MATSEQ_PERF_EN
        chk("bp_perf_stalls", 64'(perf_stalls), 64'd12);
        chk("bp_perf_cycles", 64'(perf_cycles), 64'd36);
`endif

        // 16-bit modular result: 0xFF*0x101 + 1 = 0x10000
        run_cmd(1, 2, 1, 10'h100, 10'h200, 10'h080, 1'b0);
        chk("wrapd_nwr", 64'(n_wr), 64'd1);
        chk("wrapd_data", 64'(wr_data_log[0]), 64'h0000);
        chk("wrapd_addr", 64'(wr_addr_log[0]), 64'h080);

        // address wrap from 0x3FF to 0x000
        run_cmd(1, 2, 1, 10'h3FF, 10'h300, 10'h090, 1'b0);
        chk("wrapa_rd0", 64'(rd_addr_log[0]), 64'h3FF);
        chk("wrapa_rd1", 64'(rd_addr_log[1]), 64'h000);
        chk("wrapa_data", 64'(wr_data_log[0]), 64'd17);

        // zero dimension
        run_cmd(2, 0, 2, 10'h000, 10'h010, 10'h020, 1'b0);
        chk("zero_activity", {32'(rd_cnt), 16'(load_cnt), 16'(wr_seen)}, 64'd0);
        chk("zero_busy", 64'(busy_cnt), 64'd0);
        chk("zero_done", 64'(done_cnt), 64'd1);
        chk("zero_lat", 64'(lat <= 2), 64'd1);

        // reset in the middle of a 3x3x3 command
        clear_logs();
        dim_m = 3; dim_k = 3; dim_n = 3;
        a_base = 10'h0A0; b_base = 10'h0C0; c_base = 10'h0E0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        chk("mid_pre_issue", 64'(a_rd_en), 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_ctrl", {58'd0, busy, done, a_rd_en, b_rd_en, mac_load, mac_valid}, 64'd0);
        chk("mid_rst_wr", {37'd0, c_wr_en, c_wr_addr, c_wr_data}, 64'd0);
        chk("mid_rst_addr", {12'd0, a_rd_addr, b_rd_addr, mac_a, mac_b}, 64'd0);
        rst = 1'b0;
        repeat (10) tick();
        chk("mid_no_done", 64'(done_cnt), 64'd0);
        chk("mid_idle", 64'(busy), 64'd0);
        run_cmd(1, 1, 1, 10'h050, 10'h060, 10'h070, 1'b0);
        chk("one_data", 64'(wr_data_log[0]), 64'd12);
        chk("one_addr", 64'(wr_addr_log[0]), 64'h070);
        chk("one_busy", 64'(busy_cnt), 64'd5);

        // start pulse while busy is ignored
        run_cmd(2, 2, 2, 10'h000, 10'h010, 10'h020, 1'b1);
        check_2x2("sbusy");
        chk("sbusy_busy", 64'(busy_cnt), 64'd24);
        repeat (5) tick();
        chk("sbusy_idle", {62'd0, busy, c_wr_en}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/matmul_sequencer.md
Name: matmul_sequencer

Overview:
- Controller that sequences one fused multiply-add unit through a full matrix product C = A x B. Dimensions: A is MxK, B is KxN, C is MxN.
- For each C element it does four things in order:
  - seeds the MAC accumulator;
  - streams K operand pairs from two scratchpad read ports into the MAC;
  - waits for the final accumulate;
  - writes the result to the C scratchpad with backpressure.
- Sits between the matrix-processor command interface and the arithmetic datapath.

Parameters:
- WIDTH, 16, operand, accumulator and result width.
- DIM_W, 4, width of each dimension field; dimensions 0..2^DIM_W-1.
- ADDR_W, 10, scratchpad address width; all address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- dim_m, dim_k, dim_n  in  DIM_W each  matrix dimensions, latched on accepted start.
- a_base, b_base, c_base  in  ADDR_W each  row-major base addresses, latched on accepted start.
- busy  out  1  high while a command is executing.
- done  out  1  one-cycle pulse at command completion.
- a_rd_en / b_rd_en  out  1  read strobes to the A/B scratchpads.
- a_rd_addr / b_rd_addr  out  ADDR_W  read addresses.
- a_rd_data / b_rd_data  in  WIDTH  read data, valid exactly 1 cycle after the strobe.
- mac_load  out  1  MAC accumulator-seed strobe (the updateAccumulator input).
- mac_seed  out  WIDTH  seed value.
- mac_valid  out  1  operand-pair valid (the inputGood input).
- mac_a, mac_b  out  WIDTH  operands to the MAC.
- mac_acc  in  WIDTH  MAC accumulator output.
- c_wr_en  out  1  write request, held until accepted.
- c_wr_addr  out  ADDR_W  write address.
- c_wr_data  out  WIDTH  write data.
- c_wr_ready  in  1  write accept; the transfer completes in any cycle where c_wr_en and c_wr_ready are both high.

Behaviour:
- Reset (any state, including mid-command): state=IDLE; all counters 0; every output 0. The in-flight command is abandoned and done is not pulsed.
- States and transitions:
  - IDLE: start=1 latches all dimensions and bases, zeroes i, j, k and moves to LOAD. If any dimension is 0, go directly to DONE instead (no reads, no writes).
  - LOAD, 1 cycle: mac_load=1, mac_seed=0. Moves to ISSUE with k=0.
  - ISSUE, K cycles:
    - a_rd_en=b_rd_en=1.
    - a_rd_addr = a_base + i*K + k.
    - b_rd_addr = b_base + k*N + j.
    - Increments k; after the cycle with k=K-1, moves to DRAIN.
  - DRAIN, 2 cycles:
    - cycle 1 carries the last operand pair;
    - cycle 2 waits for mac_acc to reflect the final accumulate.
    - Then moves to WRITE.
  - WRITE:
    - c_wr_en=1; c_wr_addr = c_base + i*N + j; c_wr_data = mac_acc, captured in a register on WRITE entry and held stable until accepted.
    - On accept, advance j, and on j wrap advance i. Go to LOAD, or to DONE after the (M-1, N-1) element.
  - DONE, 1 cycle: done=1, busy=0, then IDLE.
- MAC operand pipeline:
  - mac_valid is the 1-cycle delayed copy of the ISSUE read strobe.
  - mac_a and mac_b are driven combinationally from a_rd_data and b_rd_data.
  - mac_load and mac_valid are never high in the same cycle.
- busy: high in LOAD, ISSUE, DRAIN and WRITE; low in IDLE and DONE.
- start: ignored while busy or in DONE.
- Latency: with c_wr_ready tied high, busy lasts exactly M*N*(K+4) cycles; done follows in the next cycle.
- Arithmetic:
  - Index products are computed at ADDR_W width and truncated.
  - Results are the MAC's WIDTH-bit modular sum; the sequencer performs no saturation.
- Write stall: c_wr_en, c_wr_addr and c_wr_data hold while c_wr_ready=0, with no other activity.

Optional Feature:
- Macro MATSEQ_PERF_EN.
- When defined, adds two outputs:
  - perf_cycles (32 bits): counts busy cycles.
  - perf_stalls (32 bits): counts WRITE cycles with c_wr_ready=0.
- Both counters clear on rst and on accepted start, saturate at all-ones, and hold their values after done.
- When undefined, neither port nor counter exists; all other behaviour is identical.

Test Plan:
- 2x2x2 product: A=[1,2;3,4] at 0x000, B=[5,6;7,8] at 0x010, C base 0x020, c_wr_ready=1 -> writes 19@0x020, 22@0x021, 43@0x022, 50@0x023 in that order; busy for 24 cycles; one done pulse.
- Backpressure: same command with c_wr_ready low for 3 cycles at each write -> identical data and addresses, each held stable during the stall; busy lasts 36 cycles; perf_stalls=12 when MATSEQ_PERF_EN is defined.
- Wrap: WIDTH=16, K=2, A row=[0x00FF,1], B column=[0x0101,1] -> result 0x0000. Separately, a_base=0x3FF with K=2 -> second read address is 0x000.
- Zero dimension: start with dim_k=0 -> no rd_en, no mac_load, no c_wr_en; done pulses 2 cycles after start.
- Reset mid-ISSUE: assert rst during a 3x3x3 command -> next cycle all outputs 0 and no done pulse. A fresh 1x1x1 command (A=3, B=4) then writes 12, with busy lasting 5 cycles.
- Start while busy: pulse start with different dimensions mid-command -> ignored; the original results are unchanged.
